// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter.
// Build option: define PS2_TX_RETRY_EN to retry a failed frame up to twice.
module ps2_host_tx #(
    parameter int CLK_HZ     = 100000000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 15000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] tx_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       err_timeout
);

    localparam longint INH_CYC =
        longint'(INHIBIT_US) * longint'(CLK_HZ) / longint'(1000000);
    localparam longint TO_CYC =
        longint'(TIMEOUT_US) * longint'(CLK_HZ) / longint'(1000000);
    localparam longint MAX_CYC = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_RELEASE,
        S_DATA, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [3:0]    bit_cnt_q, bit_cnt_n;
    logic [9:0]    frame_q, frame_n;
    logic          data_oe_q, data_oe_n;
    logic          ack_ok_q, ack_ok_n;
    logic          err_to_q, err_to_n;
    logic          done_q, done_n;
    logic          err_q, err_n;
    logic          fail, fail_to;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]    retry_q, retry_n;
`endif

    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          fall, data_s;

    // Sync both lines; debounce the clock so ringing never counts as an edge.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_in};
            data_sync  <= {data_sync[0], ps2_data_in};
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall   = clk_filt_d & ~clk_filt;
    assign data_s = data_sync[1];

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            data_oe_q <= 1'b0;
            ack_ok_q  <= 1'b0;
            err_to_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_cnt_q <= bit_cnt_n;
            frame_q   <= frame_n;
            data_oe_q <= data_oe_n;
            ack_ok_q  <= ack_ok_n;
            err_to_q  <= err_to_n;
            done_q    <= done_n;
            err_q     <= err_n;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_n;
`endif
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_cnt_n = bit_cnt_q;
        frame_n   = frame_q;
        data_oe_n = data_oe_q;
        ack_ok_n  = ack_ok_q;
        err_to_n  = err_to_q;
        done_n    = 1'b0;
        err_n     = 1'b0;
        fail      = 1'b0;
        fail_to   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_n   = retry_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (send) begin
                    frame_n  = {1'b1, ~^tx_byte, tx_byte};
                    err_to_n = 1'b0;
                    cnt_n    = CW'(INH_CYC);
                    state_n  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_n  = '0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q <= CW'(1)) begin
                    data_oe_n = 1'b1;
                    state_n   = S_START;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            S_START: state_n = S_RELEASE;
            S_RELEASE: begin
                cnt_n     = CW'(TO_CYC);
                bit_cnt_n = '0;
                state_n   = S_DATA;
            end
            S_DATA: begin
                if (cnt_q <= CW'(1)) begin
                    fail    = 1'b1;
                    fail_to = 1'b1;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                    if (fall) begin
                        data_oe_n = ~frame_q[bit_cnt_q];
                        bit_cnt_n = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) state_n = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (cnt_q <= CW'(1)) begin
                    fail    = 1'b1;
                    fail_to = 1'b1;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                    if (fall) begin
                        ack_ok_n = ~data_s;
                        state_n  = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (cnt_q <= CW'(1)) begin
                    fail    = 1'b1;
                    fail_to = 1'b1;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                    if (clk_filt && data_s) begin
                        if (ack_ok_q) begin
                            done_n  = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Failure: release the data line, then retry or report.
        if (fail) begin
            data_oe_n = 1'b0;
            err_to_n  = fail_to;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_n = retry_q + 2'd1;
                cnt_n   = CW'(INH_CYC);
                state_n = S_INHIBIT;
            end else
`endif
            begin
                err_n   = 1'b1;
                state_n = S_IDLE;
            end
        end
    end

    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_START);
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a PS/2 device model.
// A second instance with a short timeout covers the no-device case.
module tb_ps2_host_tx;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    logic       send = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err, err_timeout;

    logic       send2 = 1'b0;
    logic       clk_in2, data_in2;
    logic       clk_oe2, data_oe2, busy2, done2, err2, to2;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);
    assign clk_in2     = ~clk_oe2;
    assign data_in2    = ~data_oe2;

    ps2_host_tx #(
        .CLK_HZ(1000000), .INHIBIT_US(120),
        .TIMEOUT_US(15000), .FILTER_LEN(2)
    ) dut (
        .clock(clock), .rst(rst), .send(send), .tx_byte(tx_byte),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .err(err), .err_timeout(err_timeout)
    );

    ps2_host_tx #(
        .CLK_HZ(1000000), .INHIBIT_US(120),
        .TIMEOUT_US(500), .FILTER_LEN(2)
    ) dut_to (
        .clock(clock), .rst(rst), .send(send2), .tx_byte(tx_byte),
        .ps2_clk_in(clk_in2), .ps2_data_in(data_in2),
        .ps2_clk_oe(clk_oe2), .ps2_data_oe(data_oe2),
        .busy(busy2), .done(done2), .err(err2), .err_timeout(to2)
    );

    typedef struct packed {
        logic        is_err;
        logic [10:0] frame;
    } exp_t;

    exp_t        exp_q[$];
    int          exp2 = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [10:0] rx_bits = '0;
    int          inh_run = 0;
    int          inh_len = 0;
    int          to_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic e, input logic p,
                                input logic [7:0] b);
        exp_t x;
        x.is_err = e;
        x.frame  = {1'b1, p, b, 1'b0};
        exp_q.push_back(x);
    endtask

    // Length of the most recent clock-inhibit phase.
    always @(negedge clock) begin
        if (ps2_clk_oe && !ps2_data_oe) begin
            inh_run++;
        end else if (inh_run != 0) begin
            inh_len = inh_run;
            inh_run = 0;
        end
    end

    always @(negedge clock) begin
        if (!rst && (done || err)) begin
            check("done_err_excl", done & err, 0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: done=%b err=%b", done, err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", err, e.is_err);
                check("err_timeout", err_timeout, 0);
                check("busy_at_pulse", busy, 0);
                check("frame_bits", rx_bits, e.frame);
            end
        end
    end

    always @(negedge clock) begin
        if (!rst && (done2 || err2)) begin
            if (exp2 == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse2: done=%b err=%b", done2, err2);
            end else begin
                exp2--;
                check("to_err", err2, 1);
                check("to_flag", to2, 1);
                check("to_oe_released", {clk_oe2, data_oe2}, 0);
                check("to_cycles_near_500",
                      (to_cnt >= 495 && to_cnt <= 505), 1);
            end
        end
        if (clk_oe2 || !busy2) to_cnt = 0;
        else to_cnt++;
    end

    task automatic issue(input logic [7:0] b);
        send    = 1'b1;
        tx_byte = b;
        @(negedge clock);
        send    = 1'b0;
    endtask

    // Device side: 12.5 kHz clock, 40 cycles low / 40 cycles high.
    task automatic device(input bit ack, input int inject_at,
                          input int abort_at);
        int n;
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge clock); n++; end
        n = 0;
        while (ps2_clk_oe && n < 1000) begin @(negedge clock); n++; end
        check("inhibit_cycles", inh_len, 120);
        repeat (20) @(negedge clock);
        rx_bits    = '0;
        rx_bits[0] = ps2_data_in;
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (10) @(negedge clock);
            end
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clock);
            if (i == inject_at) begin
                check("busy_mid_frame", busy, 1);
                issue(8'h00);
            end
            dev_clk_low = 1'b0;
            repeat (20) @(negedge clock);
            if (i < 10) rx_bits[i+1] = ps2_data_in;
            if (i == abort_at) return;
            repeat (20) @(negedge clock);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic await_pulse(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (100) @(negedge clock);
    endtask

    initial begin
        repeat (90000) @(negedge clock);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {done, err, err_timeout}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clock);

        expect_pulse(1'b0, 1'b1, 8'hED);
        issue(8'hED);
        device(1'b1, -1, -1);
        await_pulse("ed_done_seen");

        expect_pulse(1'b0, 1'b0, 8'hF4);
        issue(8'hF4);
        device(1'b1, -1, -1);
        await_pulse("f4_done_seen");

        expect_pulse(1'b1, 1'b1, 8'hED);
        issue(8'hED);
        device(1'b0, -1, -1);
`ifdef PS2_TX_RETRY_EN
        device(1'b0, -1, -1);
        device(1'b0, -1, -1);
`endif
        await_pulse("nack_err_seen");

        expect_pulse(1'b0, 1'b1, 8'hED);
        issue(8'hED);
        device(1'b1, 3, -1);
        await_pulse("busy_protect_done");

        issue(8'h00);
        device(1'b1, -1, 5);
        check("data_oe_before_rst", ps2_data_oe, 1);
        rst = 1'b1;
        #1;
        check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pulses", {done, err}, 0);
        @(negedge clock);
        rst = 1'b0;
        repeat (200) @(negedge clock);

        expect_pulse(1'b0, 1'b1, 8'hFF);
        issue(8'hFF);
        device(1'b1, -1, -1);
        await_pulse("ff_after_rst_done");

        issue(8'h55);
        repeat (10) @(negedge clock);
        check("inhibit_clk_oe", ps2_clk_oe, 1);
        rst = 1'b1;
        #1;
        check("inhibit_rst_clk_oe", ps2_clk_oe, 0);
        @(negedge clock);
        rst = 1'b0;
        repeat (50) @(negedge clock);

        exp2 = 1;
        send2 = 1'b1;
        @(negedge clock);
        send2 = 1'b0;
        for (int n = 0; n < 3000 && exp2 != 0; n++) @(negedge clock);
        check("timeout_err_seen", exp2, 0);
        repeat (50) @(negedge clock);
        check("timeout_flag_held", to2, 1);
        check("timeout_idle", busy2, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
